// File: rtl/wb_seg_pipe.sv
// Write-back segment: decodes the retiring IR and drives a registered register-file write port.
// Latency: 1 cycle from accept (or from load-data arrival) to a WB_Write pulse.
// Backpressure: in_ready drops while a load waits for data; in_valid is ignored until data or flush.
module wb_seg_pipe #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       IR_i,
    input  logic [DATA_W-1:0] ALUo_i,
    input  logic [DATA_W-1:0] LMD_i,
    input  logic              LMD_valid,
    input  logic              flush,
    output logic [DATA_W-1:0] WB_Data,
    output logic              WB_Write,
    output logic [4:0]        WB_Addr,
    output logic              busy,
    output logic [CNT_W-1:0]  retired_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [5:0]        op;
    logic [4:0]        dec_dest;
    logic              dec_wr;
    logic              dec_load;
    logic              accept;
    logic [4:0]        ld_rt;
    logic              ld_latch;
    logic              wr_fire;
    logic [4:0]        wr_addr_nxt;
    logic [DATA_W-1:0] wr_data_nxt;
    logic              retire;

    assign in_ready = (state == IDLE);
    assign busy     = (state == WAIT_LOAD);
    assign accept   = in_valid & in_ready & ~flush;

    // Instruction decode: destination register and whether the op writes at all.
    always_comb begin
        op       = IR_i[31:26];
        dec_dest = 5'd0;
        dec_wr   = 1'b0;
        dec_load = 1'b0;
        case (op)
            OP_RTYPE: begin
                if (IR_i != 32'd0) begin
                    dec_dest = IR_i[15:11];
                    dec_wr   = 1'b1;
                end
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                dec_dest = IR_i[20:16];
                dec_wr   = 1'b1;
            end
            OP_LW: begin
                dec_dest = IR_i[20:16];
                dec_wr   = 1'b1;
                dec_load = 1'b1;
            end
            OP_JAL: begin
                dec_dest = 5'd31;
                dec_wr   = 1'b1;
            end
            default: begin
                dec_dest = 5'd0;
                dec_wr   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and write-port decisions; a dest of r0 still retires but never writes.
    always_comb begin
        state_nxt   = state;
        ld_latch    = 1'b0;
        wr_fire     = 1'b0;
        wr_addr_nxt = WB_Addr;
        wr_data_nxt = WB_Data;
        retire      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (dec_load && !LMD_valid) begin
                        ld_latch  = 1'b1;
                        state_nxt = WAIT_LOAD;
                    end else begin
                        retire = 1'b1;
                        if (dec_wr && (dec_dest != 5'd0)) begin
                            wr_fire     = 1'b1;
                            wr_addr_nxt = dec_dest;
                            wr_data_nxt = dec_load ? LMD_i : ALUo_i;
                        end
                    end
                end
            end
            WAIT_LOAD: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (LMD_valid) begin
                    state_nxt = IDLE;
                    retire    = 1'b1;
                    if (ld_rt != 5'd0) begin
                        wr_fire     = 1'b1;
                        wr_addr_nxt = ld_rt;
                        wr_data_nxt = LMD_i;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_Write    <= 1'b0;
            WB_Addr     <= 5'd0;
            WB_Data     <= '0;
            retired_cnt <= '0;
            ld_rt       <= 5'd0;
        end else begin
            WB_Write <= wr_fire;
            if (wr_fire) begin
                WB_Addr <= wr_addr_nxt;
                WB_Data <= wr_data_nxt;
            end
            if (retire) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
            if (ld_latch) begin
                ld_rt <= dec_dest;
            end
        end
    end

endmodule

// File: tb/tb_wb_seg_pipe.sv
// Directed bench for wb_seg_pipe with a 4-bit retire counter so wrap-around is reachable.
module tb_wb_seg_pipe;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       IR_i;
    logic [DATA_W-1:0] ALUo_i;
    logic [DATA_W-1:0] LMD_i;
    logic              LMD_valid;
    logic              flush;
    logic [DATA_W-1:0] WB_Data;
    logic              WB_Write;
    logic [4:0]        WB_Addr;
    logic              busy;
    logic [CNT_W-1:0]  retired_cnt;

    int total = 0;
    int bad   = 0;

    wb_seg_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .IR_i        (IR_i),
        .ALUo_i      (ALUo_i),
        .LMD_i       (LMD_i),
        .LMD_valid   (LMD_valid),
        .flush       (flush),
        .WB_Data     (WB_Data),
        .WB_Write    (WB_Write),
        .WB_Addr     (WB_Addr),
        .busy        (busy),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic w, input logic [4:0] a,
                          input logic [31:0] d, input logic [3:0] c);
        chk({tag, ".wr"},   64'(WB_Write),    64'(w));
        chk({tag, ".addr"}, 64'(WB_Addr),     64'(a));
        chk({tag, ".data"}, 64'(WB_Data),     64'(d));
        chk({tag, ".cnt"},  64'(retired_cnt), 64'(c));
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; IR_i = 32'd0; ALUo_i = '0;
        LMD_i = '0; LMD_valid = 1'b0; flush = 1'b0;
        #23;
        chk_wb("reset", 1'b0, 5'd0, 32'd0, 4'd0);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.rdy", 64'(in_ready), 64'd1);
        rst = 1'b1;
        step();

        // add rd=3
        in_valid = 1'b1; IR_i = 32'h00A41820; ALUo_i = 32'd456;
        step();
        chk_wb("add", 1'b1, 5'd3, 32'd456, 4'd1);
        in_valid = 1'b0;
        step();
        chk_wb("add.hold", 1'b0, 5'd3, 32'd456, 4'd1);

        // delayed load rt=8, MEM holds IR while stalled
        in_valid = 1'b1; IR_i = 32'h8C080000; ALUo_i = 32'hDEAD0000; LMD_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lw.busy", 64'(busy), 64'd1);
            chk("lw.rdy", 64'(in_ready), 64'd0);
            chk("lw.nowr", 64'(WB_Write), 64'd0);
        end
        LMD_i = 32'd123; LMD_valid = 1'b1;
        step();
        chk_wb("lw.done", 1'b1, 5'd8, 32'd123, 4'd2);
        chk("lw.idle", 64'(in_ready), 64'd1);
        in_valid = 1'b0; LMD_valid = 1'b0;
        step();
        chk("lw.pulse", 64'(WB_Write), 64'd0);

        // sw, NOP, addi rt=0: retire without writing
        in_valid = 1'b1; ALUo_i = 32'd77;
        IR_i = 32'hAC080000; step(); chk_wb("sw", 1'b0, 5'd8, 32'd123, 4'd3);
        IR_i = 32'h00000000; step(); chk_wb("nop", 1'b0, 5'd8, 32'd123, 4'd4);
        IR_i = 32'h20000005; step(); chk_wb("addi0", 1'b0, 5'd8, 32'd123, 4'd5);

        // lw with data already valid completes immediately
        IR_i = 32'h8C080000; LMD_i = 32'h55; LMD_valid = 1'b1;
        step();
        chk_wb("lw.imm", 1'b1, 5'd8, 32'h55, 4'd6);
        chk("lw.imm.busy", 64'(busy), 64'd0);
        LMD_valid = 1'b0;

        // flush in IDLE discards the presented add
        IR_i = 32'h00A41820; ALUo_i = 32'd999; flush = 1'b1;
        step();
        chk_wb("flush.idle", 1'b0, 5'd8, 32'h55, 4'd6);
        chk("flush.idle.rdy", 64'(in_ready), 64'd1);

        // flush a pending load with simultaneous LMD_valid
        flush = 1'b0; IR_i = 32'h8C080000;
        step();
        chk("flush.ld.busy", 64'(busy), 64'd1);
        in_valid = 1'b0; flush = 1'b1; LMD_valid = 1'b1; LMD_i = 32'd77;
        step();
        chk_wb("flush.ld", 1'b0, 5'd8, 32'h55, 4'd6);
        chk("flush.ld.rdy", 64'(in_ready), 64'd1);
        flush = 1'b0; LMD_valid = 1'b0;
        step();
        chk_wb("flush.ld.after", 1'b0, 5'd8, 32'h55, 4'd6);

        // slti rt=5, then beq (no write)
        in_valid = 1'b1; IR_i = 32'h28050001; ALUo_i = 32'd1;
        step(); chk_wb("slti", 1'b1, 5'd5, 32'd1, 4'd7);
        IR_i = 32'h10000000; ALUo_i = 32'd42;
        step(); chk_wb("beq", 1'b0, 5'd5, 32'd1, 4'd8);

        // jal writes r31
        IR_i = 32'h0C000010; ALUo_i = 32'h00400008;
        step(); chk_wb("jal", 1'b1, 5'd31, 32'h00400008, 4'd9);

        // reset mid-WAIT_LOAD
        IR_i = 32'h8C080000;
        step();
        chk("rst.pre.busy", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk_wb("rst.async", 1'b0, 5'd0, 32'd0, 4'd0);
        chk("rst.async.busy", 64'(busy), 64'd0);
        #1 rst = 1'b1;
        in_valid = 1'b0; LMD_valid = 1'b1; LMD_i = 32'd99;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_wb("rst.after", 1'b0, 5'd0, 32'd0, 4'd0);
        end
        LMD_valid = 1'b0;

        // 17 back-to-back ori rt=9: write every cycle, counter wraps to 1
        in_valid = 1'b1; IR_i = 32'h34090001;
        for (int i = 0; i < 17; i++) begin
            ALUo_i = 32'(i + 100);
            step();
            chk_wb("ori", 1'b1, 5'd9, 32'(i + 100), 4'((i + 1) % 16));
        end
        in_valid = 1'b0;
        step();
        chk_wb("ori.end", 1'b0, 5'd9, 32'd116, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_seg_pipe.md
Name: wb_seg_pipe

Overview:
- Parametrised write-back segment for the R/I/J pipeline. Successor to the fixed 32-bit, single-cycle write-back stage.
- Accepts one retiring instruction per cycle from MEM over a valid/ready handshake.
- Decodes destination and source from the IR and drives a registered register-file write port.
- Adds variable-latency load completion (waits for load data), flush support and a retired-instruction counter.

Parameters:
- DATA_W, 32, width of ALUo_i, LMD_i and WB_Data.
- CNT_W, 16, width of retired_cnt.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  MEM presents an instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- IR_i  in  32  instruction word.
- ALUo_i  in  DATA_W  ALU result / link value.
- LMD_i  in  DATA_W  load data.
- LMD_valid  in  1  LMD_i is valid this cycle.
- flush  in  1  discard the current or pending instruction.
- WB_Data  out  DATA_W  register-file write data.
- WB_Write  out  1  register-file write enable, one-cycle pulse.
- WB_Addr  out  5  register-file write address.
- busy  out  1  waiting for load data.
- retired_cnt  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (rst=0, asynchronous):
  - WB_Data=0, WB_Write=0, WB_Addr=0, retired_cnt=0, busy=0.
  - State=IDLE. Any pending load is discarded.
- Decode, with op=IR_i[31:26]:
  - op 000000 with IR_i!=0: dest rd=IR_i[15:11], data ALUo_i.
  - IR_i==0: NOP, no write.
  - op 001000 / 001100 / 001101 / 001010 (addi/andi/ori/slti): dest rt=IR_i[20:16], data ALUo_i.
  - op 100011 (lw): dest rt, data LMD_i.
  - op 000011 (jal): dest 31, data ALUo_i.
  - All other ops (sw 101011, beq 000100, j 000010, unknown): no write.
  - A decoded dest of 0 suppresses the write. The instruction still retires.
- Accept = in_valid & in_ready & ~flush.
- State IDLE (in_ready=1, busy=0):
  - Accept of a non-load: on that edge, register WB_Addr/WB_Data; WB_Write=1 for exactly the next cycle if a write is due; retired_cnt+1.
  - Accept of lw with LMD_valid=1 in the same cycle: completes like a non-load, using LMD_i.
  - Accept of lw with LMD_valid=0: latch rt, go to WAIT_LOAD, no write.
- State WAIT_LOAD (in_ready=0, busy=1):
  - LMD_valid=1 and flush=0: register LMD_i and the latched rt; WB_Write=1 next cycle (unless rt=0); retired_cnt+1; return to IDLE.
  - flush=1: return to IDLE with no write and no count. flush has priority over a simultaneous LMD_valid.
  - in_valid is ignored in WAIT_LOAD. MEM must hold IR_i until in_ready.
- flush in IDLE: the presented instruction is discarded (no write, no count). in_ready stays 1.
- WB_Write is a single-cycle pulse per write. WB_Data/WB_Addr hold their last written values between writes.
- Latency: accept edge to WB_Write high is 1 cycle. For a delayed load it is 1 cycle after the LMD_valid edge.
- Back-to-back non-loads: one write per cycle, no bubbles.
- retired_cnt wraps modulo 2^CNT_W.
- rst asserted mid-WAIT_LOAD: the load is abandoned, no write afterward.
- LMD_valid in IDLE without an accepted lw is ignored.

Test Plan:
1. Reset then add: IR=0x00A41820 (rd=3), ALUo=456, in_valid=1 for 1 cycle -> next cycle WB_Write=1, WB_Addr=3, WB_Data=456, retired_cnt=1; following cycle WB_Write=0, Addr/Data held.
2. lw rt=8: IR=0x8C080000 with LMD_valid=0 for 3 cycles, then LMD_i=123 with LMD_valid=1 -> in_ready=0 and busy=1 during the wait; one cycle after LMD_valid, WB_Write=1, WB_Addr=8, WB_Data=123; back in IDLE.
3. Non-writing and degenerate instructions: sw 0xAC080000, NOP 0x00000000, and addi with rt=0 (0x20000005), one per cycle -> WB_Write stays 0 throughout; retired_cnt +3.
4. Flush a pending load: lw pending, then flush=1 together with LMD_valid=1 -> no write, state IDLE, retired_cnt unchanged, in_ready=1 next cycle.
5. jal IR=0x0C000010, ALUo=0x00400008 -> WB_Addr=31, WB_Data=0x00400008. Then assert rst low mid-WAIT_LOAD -> all outputs 0 immediately (asynchronously), and no write occurs after release.
6. Counter wrap with CNT_W=4: 17 back-to-back ori instructions (0x34090001) -> a write every cycle (17 WB_Write pulses, no bubbles); retired_cnt wraps 15 -> 0 and ends at 1.
